pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Measures an incoming PWM waveform and reports its period and high time in clock cycles. It is the receive-side counterpart of the PWM generator core.
- Sits behind the same Wishbone register block.
- Samples external/loopback `i_pwm`, synchronises it, and latches period/duty once per full waveform cycle.
- Flags loss of edges (0 %/100 % duty or dead input) as a timeout, and reports the static level.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on `i_pwm`; minimum 2.
- CNT_W, 16, width of the period/duty counters and outputs.

Ports:
- clk  input  1  core clock (clock-divider output, ext clk or wb clk)
- rst  input  1  synchronous, active-low reset
- capture_EN  input  1  capture enable (ctrl bit); low forces IDLE
- i_pwm  input  1  asynchronous PWM input to measure
- i_timeout  input  CNT_W  timeout limit in clk cycles without a rising edge; 0 = no timeout, counter saturation only
- o_period  output  CNT_W  last measured period, rising edge to rising edge, in cycles
- o_duty  output  CNT_W  last measured high time, in cycles
- o_valid  output  1  one-cycle pulse when `o_period`/`o_duty` update
- o_timeout  output  1  level; high while in TIMEOUT
- o_level  output  1  synchronised `i_pwm` level (meaningful during timeout)

Behaviour:
- Reset (`rst`=0 at a clk edge):
  - all outputs 0, counters 0, synchroniser flops 0, state IDLE.
  - Reset mid-measurement discards the partial measurement.
- Sync and edge detect:
  - `s` = last synchroniser stage; `p` = `s` delayed one cycle.
  - `rise` = `s` & ~`p`.
  - Latency from an `i_pwm` rise to the `rise` cycle is SYNC_STAGES cycles.
- Counters, updated every cycle while `capture_EN`=1:
  - On a `rise` cycle: `per_cnt` <= 1, `hi_cnt` <= 1.
  - Otherwise: `per_cnt` <= `per_cnt`+1 and `hi_cnt` <= `hi_cnt`+`s`.
  - Both saturate at all-ones and never wrap.
- State IDLE:
  - `o_timeout`=0.
  - First `rise` -> MEASURE. No `o_valid`, because the first edge gives no full cycle.
- State MEASURE:
  - On `rise`: `o_period` <= `per_cnt`, `o_duty` <= `hi_cnt` (pre-update values), `o_valid` <= 1 for exactly one cycle. Outputs are registered, so they appear the cycle after `rise`.
  - If (`i_timeout`!=0 and `per_cnt` >= `i_timeout`) or `per_cnt` == all-ones, with no `rise` this cycle -> TIMEOUT.
  - When timeout and `rise` coincide, `rise` wins: a normal measurement is taken.
- State TIMEOUT:
  - `o_timeout`=1.
  - `o_period` <= 0; `o_duty` <= all-ones if `s`=1, else 0. These update continuously, with no `o_valid`.
  - `rise` -> MEASURE with counters restarted and no `o_valid`; `o_timeout` drops the cycle after `rise`.
- Enable: `capture_EN`=0 -> IDLE next cycle.
  - Counters are cleared and `o_timeout`=0.
  - `o_period`/`o_duty` hold their last values.
  - Synchroniser keeps running.
- Valid `o_duty` <= `o_period` always holds. Duty equals period only if a fall is shorter than the sampling resolution, which is reported as measured.
- `o_level` = `s`, always, including in IDLE.
- Correspondence with the generator: generator `period_reg`=P and duty D (D<=P) gives `o_period`=P+1 and `o_duty`=D.

Decomposition:
- Shared package:
  - state encoding IDLE=2'd0, MEASURE=2'd1, TIMEOUT=2'd2
  - default CNT_W=16
  - saturation constant CNT_MAX
- One sub-module, `pwm_in_sync`: SYNC_STAGES-flop synchroniser plus edge register.
  - Outputs: `s`, `rise`, `fall`.
  - Synchronous active-low reset.
- `pwm_capture` holds the FSM, counters and output registers.

Test Plan:
- Generator-equivalent wave, period 10 cycles, high 3, `capture_EN`=1, `i_timeout`=100:
  - no `o_valid` on the first edge;
  - then `o_valid` once per 10 cycles with `o_period`=10, `o_duty`=3;
  - first valid exactly SYNC_STAGES+1 cycles after the second input rise.
- `i_pwm` held 1 after a valid run, `i_timeout`=50:
  - `o_timeout`=1 after 50 cycles from the last rise;
  - `o_duty`=16'hFFFF, `o_period`=0, `o_level`=1.
  - Restart the wave: the first rise clears `o_timeout`, no valid; the next rise gives a correct valid.
- `i_timeout`=0, `i_pwm` constant 0 for 70000 cycles:
  - `per_cnt` saturates at 16'hFFFF;
  - TIMEOUT entered with `o_duty`=0 and no wrap-around.
- Reset low for 1 cycle mid-period:
  - all outputs 0, state IDLE;
  - the next two rises yield one valid with correct values.
- `capture_EN` deasserted mid-period then reasserted:
  - `o_period`/`o_duty` hold the old values;
  - no valid until the second rise after re-enable.
- Period change from 10/3 to 20/15 mid-stream:
  - the first full new cycle reports exactly 20/15;
  - any mixed boundary cycle reports the actual edge-to-edge counts.

Source files
------------

// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM capture block: FSM encoding and counter sizing.
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TIMEOUT = 2'd2
  } cap_state_e;

  localparam int CNT_W_DEFAULT = 16;
  localparam logic [CNT_W_DEFAULT-1:0] CNT_MAX = '1;

endpackage

// File: rtl/pwm_in_sync.sv
// Synchronises the async PWM input and flags its edges; s lags pwm by SYNC_STAGES cycles.
// rise/fall are combinational from s and its one-cycle-delayed copy; no backpressure.
module pwm_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   p;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
      p      <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm};
      p      <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~p;
  assign fall = ~s & p;

endmodule

// File: rtl/pwm_capture.sv
// Measures PWM period/high time between synchronised rising edges; results registered one cycle after rise.
// Free-running receiver with no backpressure; loss of edges is reported as a timeout level.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture_EN,
  input  logic             i_pwm,
  input  logic [CNT_W-1:0] i_timeout,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_duty,
  output logic             o_valid,
  output logic             o_timeout,
  output logic             o_level
);

  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  logic             s;
  logic             rise;
  logic             fall;
  cap_state_e       state;
  cap_state_e       state_nxt;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] hi_cnt;
  logic [CNT_W-1:0] per_nxt;
  logic [CNT_W-1:0] hi_nxt;
  logic [CNT_W-1:0] period_nxt;
  logic [CNT_W-1:0] duty_nxt;
  logic             valid_nxt;
  logic             timeout_hit;

  pwm_in_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .pwm (i_pwm),
    .s   (s),
    .rise(rise),
    .fall(fall)
  );

  // Saturation doubles as the timeout when the programmable limit is zero.
  assign timeout_hit = ((i_timeout != '0) && (per_cnt >= i_timeout)) || (per_cnt == ALL_ONES);

  always_comb begin
    state_nxt  = state;
    per_nxt    = per_cnt;
    hi_nxt     = hi_cnt;
    period_nxt = o_period;
    duty_nxt   = o_duty;
    valid_nxt  = 1'b0;

    if (!capture_EN) begin
      state_nxt = IDLE;
      per_nxt   = '0;
      hi_nxt    = '0;
    end else begin
      if (rise) begin
        per_nxt = CNT_W'(1);
        hi_nxt  = CNT_W'(1);
      end else begin
        per_nxt = (per_cnt == ALL_ONES) ? per_cnt : per_cnt + CNT_W'(1);
        hi_nxt  = (s && (hi_cnt != ALL_ONES)) ? hi_cnt + CNT_W'(1) : hi_cnt;
      end

      case (state)
        IDLE: begin
          if (rise) state_nxt = MEASURE;
        end
        MEASURE: begin
          // A rise in the same cycle as the limit still yields a measurement.
          if (rise) begin
            period_nxt = per_cnt;
            duty_nxt   = hi_cnt;
            valid_nxt  = 1'b1;
          end else if (timeout_hit) begin
            state_nxt = TIMEOUT;
          end
        end
        TIMEOUT: begin
          period_nxt = '0;
          duty_nxt   = s ? ALL_ONES : '0;
          if (rise) state_nxt = MEASURE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      per_cnt  <= '0;
      hi_cnt   <= '0;
      o_period <= '0;
      o_duty   <= '0;
      o_valid  <= 1'b0;
    end else begin
      state    <= state_nxt;
      per_cnt  <= per_nxt;
      hi_cnt   <= hi_nxt;
      o_period <= period_nxt;
      o_duty   <= duty_nxt;
      o_valid  <= valid_nxt;
    end
  end

  assign o_timeout = (state == TIMEOUT);
  assign o_level   = s;

  a_edge_excl : assert property (@(posedge clk) disable iff (!rst) !(rise && fall));

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: latency, timeout, saturation, reset, enable and period change.
module tb_pwm_capture;
  import pwm_capture_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             capture_en;
  logic             i_pwm;
  logic [CNT_W-1:0] i_timeout;
  logic [CNT_W-1:0] o_period;
  logic [CNT_W-1:0] o_duty;
  logic             o_valid;
  logic             o_timeout;
  logic             o_level;

  int checks = 0;
  int errors = 0;
  int valid_total = 0;
  logic [CNT_W-1:0] last_per = '0;
  logic [CNT_W-1:0] last_duty = '0;

  pwm_capture #(
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .capture_EN(capture_en),
    .i_pwm     (i_pwm),
    .i_timeout (i_timeout),
    .o_period  (o_period),
    .o_duty    (o_duty),
    .o_valid   (o_valid),
    .o_timeout (o_timeout),
    .o_level   (o_level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      valid_total <= valid_total + 1;
      last_per    <= o_period;
      last_duty   <= o_duty;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_wave(input int per, input int hi, input int n);
    for (int c = 0; c < n; c++) begin
      for (int k = 0; k < per; k++) begin
        i_pwm = (k < hi);
        @(negedge clk);
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int base;
    int n;

    rst        = 1'b0;
    capture_en = 1'b0;
    i_pwm      = 1'b0;
    i_timeout  = '0;
    idle_cycles(2);
    check("rst_period", 32'(o_period), 32'(0));
    check("rst_duty", 32'(o_duty), 32'(0));
    check("rst_valid", 32'(o_valid), 32'(0));
    check("rst_timeout", 32'(o_timeout), 32'(0));
    check("rst_level", 32'(o_level), 32'(0));

    // Basic 10/3 waveform
    rst        = 1'b1;
    capture_en = 1'b1;
    i_timeout  = 16'd100;
    idle_cycles(3);
    base = valid_total;
    drive_wave(10, 3, 1);
    check("first_edge_no_valid", 32'(valid_total - base), 32'(0));
    for (int k = 0; k < 10; k++) begin
      i_pwm = (k < 3);
      @(negedge clk);
      if (k == SYNC_STAGES - 1) check("valid_early", 32'(o_valid), 32'(0));
      if (k == SYNC_STAGES) begin
        check("valid_latency", 32'(o_valid), 32'(1));
        check("first_period", 32'(o_period), 32'(10));
        check("first_duty", 32'(o_duty), 32'(3));
      end
    end
    base = valid_total;
    drive_wave(10, 3, 5);
    check("stream_count", 32'(valid_total - base), 32'(5));
    check("stream_period", 32'(last_per), 32'(10));
    check("stream_duty", 32'(last_duty), 32'(3));

    // Input stuck high: programmable timeout
    i_timeout = 16'd50;
    base = valid_total;
    i_pwm = 1'b1;
    n = 0;
    while (o_timeout !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("timeout_delay", 32'(n), 32'(SYNC_STAGES + 1 + 50));
    @(negedge clk);
    check("to_flag", 32'(o_timeout), 32'(1));
    check("to_duty_hi", 32'(o_duty), 32'(CNT_MAX));
    check("to_period", 32'(o_period), 32'(0));
    check("to_level", 32'(o_level), 32'(1));
    check("to_last_valid", 32'(valid_total - base), 32'(1));
    check("to_last_per", 32'(last_per), 32'(10));

    i_pwm = 1'b0;
    idle_cycles(5);
    check("to_duty_lo", 32'(o_duty), 32'(0));
    check("to_still", 32'(o_timeout), 32'(1));
    base = valid_total;
    drive_wave(10, 3, 1);
    check("restart_clear", 32'(o_timeout), 32'(0));
    check("restart_no_valid", 32'(valid_total - base), 32'(0));
    drive_wave(10, 3, 1);
    check("restart_valid", 32'(valid_total - base), 32'(1));
    check("restart_period", 32'(last_per), 32'(10));
    check("restart_duty", 32'(last_duty), 32'(3));

    // No programmable limit: counter saturation ends the measurement
    i_timeout = '0;
    base = valid_total;
    n = 0;
    while (o_timeout !== 1'b1 && n < 70000) begin
      @(negedge clk);
      n++;
    end
    check("sat_timeout", 32'(o_timeout), 32'(1));
    check("sat_not_early", 32'(n >= 65000), 32'(1));
    @(negedge clk);
    check("sat_period", 32'(o_period), 32'(0));
    check("sat_duty", 32'(o_duty), 32'(0));
    check("sat_cnt", 32'(dut.per_cnt), 32'(CNT_MAX));
    idle_cycles(10);
    check("sat_hold_flag", 32'(o_timeout), 32'(1));
    check("sat_no_wrap", 32'(dut.per_cnt), 32'(CNT_MAX));
    check("sat_no_valid", 32'(valid_total - base), 32'(0));

    // Reset mid-period
    drive_wave(10, 3, 2);
    drive_wave(5, 3, 1);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_period", 32'(o_period), 32'(0));
    check("mrst_duty", 32'(o_duty), 32'(0));
    check("mrst_valid", 32'(o_valid), 32'(0));
    check("mrst_timeout", 32'(o_timeout), 32'(0));
    check("mrst_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b1;
    base = valid_total;
    drive_wave(10, 3, 2);
    check("mrst_count", 32'(valid_total - base), 32'(1));
    check("mrst_res_per", 32'(last_per), 32'(10));
    check("mrst_res_duty", 32'(last_duty), 32'(3));

    // Enable dropped mid-period
    drive_wave(12, 5, 2);
    check("pre_en_per", 32'(last_per), 32'(12));
    check("pre_en_duty", 32'(last_duty), 32'(5));
    i_pwm = 1'b1;
    idle_cycles(4);
    capture_en = 1'b0;
    i_pwm = 1'b0;
    base = valid_total;
    idle_cycles(6);
    check("en_hold_per", 32'(o_period), 32'(12));
    check("en_hold_duty", 32'(o_duty), 32'(5));
    check("en_timeout", 32'(o_timeout), 32'(0));
    check("en_cnt_clr", 32'(dut.per_cnt), 32'(0));
    capture_en = 1'b1;
    drive_wave(10, 3, 1);
    check("reen_no_valid", 32'(valid_total - base), 32'(0));
    drive_wave(10, 3, 1);
    check("reen_valid", 32'(valid_total - base), 32'(1));
    check("reen_per", 32'(last_per), 32'(10));
    check("reen_duty", 32'(last_duty), 32'(3));

    // Period change with a short mixed cycle in between
    drive_wave(7, 3, 1);
    drive_wave(20, 15, 1);
    check("mix_per", 32'(last_per), 32'(7));
    check("mix_duty", 32'(last_duty), 32'(3));
    drive_wave(20, 15, 1);
    check("new_per", 32'(last_per), 32'(20));
    check("new_duty", 32'(last_duty), 32'(15));
    check("new_out_duty", 32'(o_duty), 32'(15));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
